// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes, default
// operand width and the counter-width helper.
package serial_adder_ctrl_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ceil(log2(value)), never less than 1 so a counter always has a bit
    function automatic int sa_clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder.
// With SERIAL_ADDER_OVF_EN defined the bundle also carries the signed
// overflow flag ovf.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
    #(parameter int WIDTH = SA_DEFAULT_WIDTH);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum, cout, ovf);
`else
    modport master (output start, a_in, b_in, cin,
                    input  busy, done, sum, cout);
    modport slave  (input  start, a_in, b_in, cin,
                    output busy, done, sum, cout);
`endif

endinterface

// File: rtl/full_adder_bh.sv
// Existing 1-bit behavioural full adder used as the bit-slice of the
// serial adder.
module full_adder_bh (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);

    // Sum and carry of one bit position
    always_comb begin
        s = a ^ b ^ cin;
        c = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one LSB-first bit pair per clock through a
// single full_adder_bh, carry recirculated through a register.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed-overflow
// output ovf.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; result registers hold the last answer
// ST_SHIFT | one bit per cycle through the full adder (busy=1)
// ST_DONE  | result just updated (done=1); start here reloads at once
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
    #(parameter int WIDTH = SA_DEFAULT_WIDTH)
(
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int             CW   = sa_clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] ps_reg;
    logic             c_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] ps_next;
    logic             last_bit;

    full_adder_bh u_fa (
        .s   (fa_s),
        .c   (fa_c),
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .cin (c_reg)
    );

    assign ps_next  = {fa_s, ps_reg[WIDTH-1:1]};
    assign last_bit = (state == ST_SHIFT) && (cnt == LAST);

    // Sequencing FSM with operand shifters, carry register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            ps_reg <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_reg <= bus.a_in;
                        b_reg <= bus.b_in;
                        c_reg <= bus.cin;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    ps_reg <= ps_next;
                    c_reg  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result registers change only on the completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (last_bit) begin
            sum_reg  <= ps_next;
            cout_reg <= fa_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // In the final cycle c_reg is the carry into the MSB and fa_c the carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= c_reg ^ fa_c;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;

endmodule
